// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store sequencer.
package data_mem_ctrl_pkg;

  localparam int OPCODE_WIDTH = 7;
  localparam int FUNCT3_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 7'b0100011;

  localparam logic [FUNCT3_WIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LHU = 3'b101;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op,
                                    input logic [FUNCT3_WIDTH-1:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OPCODE_LOAD) begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end else if (op == OPCODE_STORE) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return ok;
  endfunction

  // funct3[1:0] carries the access size for every legal load/store encoding.
  function automatic logic is_aligned(input logic [FUNCT3_WIDTH-1:0] f3,
                                      input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] size_be(input logic [FUNCT3_WIDTH-1:0] f3);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_BYTE;
      2'b01:   be = BE_HALF;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align_ext.sv
// Combinational load lane extraction with sign/zero extension selected by funct3.
module load_align_ext
  import data_mem_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            rdata,
  input  logic [1:0]              off,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  output logic [N-1:0]            data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*off +: 8];
  assign half_sel = rdata[16*off[1] +: 16];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(N-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(N-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(N-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(N-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store sequencer to a variable-latency data memory,
// with alignment checks, lane steering and a watchdog that converts a hung memory into an error.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [N-1:0]            addr,
  input  logic [N-1:0]            wdata,
  output logic                    resp_valid,
  output logic [N-1:0]            resp_rdata,
  output logic                    resp_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [N-1:0]            mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic                    mem_ack,
  input  logic [N-1:0]            mem_rdata
);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FUNCT3_WIDTH-1:0] f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic                    load_q, load_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [N-1:0]            mem_addr_q, mem_addr_d;
  logic [N-1:0]            mem_wdata_q, mem_wdata_d;
  logic                    resp_err_q, resp_err_d;
  logic [N-1:0]            resp_rdata_q, resp_rdata_d;

  logic [N-1:0]            ld_data;
  logic                    is_store;
  logic [N-1:0]            st_lanes;

  load_align_ext #(.N(N)) u_load_align_ext (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  assign is_store = (opcode == OPCODE_STORE);

  always_comb begin
    case (funct3[1:0])
      2'b00:   st_lanes = {4{wdata[7:0]}};
      2'b01:   st_lanes = {2{wdata[15:0]}};
      default: st_lanes = wdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    load_d       = load_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d   = funct3;
          off_d  = addr[1:0];
          load_d = ~is_store;
          if (is_legal(opcode, funct3) && is_aligned(funct3, addr[1:0])) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_be_d    = is_store ? (size_be(funct3) << addr[1:0]) : BE_WORD;
            mem_addr_d  = {addr[N-1:2], 2'b00};
            mem_wdata_d = is_store ? st_lanes : '0;
          end else begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end

      ACCESS: begin
        // An ack arriving in the final watchdog cycle still completes normally.
        if (mem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d      = RESP;
          cnt_d        = '0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = '0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          resp_err_d   = ~mem_ack;
          resp_rdata_d = (mem_ack && load_q) ? ld_data : '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      load_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      load_q       <= load_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Table-driven bench with a response scoreboard for data_mem_ctrl.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int TO = 8;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  data_mem_ctrl #(.N(32), .TIMEOUT(TO), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    int          exp_reqs;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input int reqs,
                              input logic we, input logic [3:0] be,
                              input logic [31:0] maddr, input logic [31:0] mwd,
                              input logic err, input logic [31:0] erd, input int cyc);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.ack_at = ack_at; v.exp_reqs = reqs; v.exp_we = we; v.exp_be = be;
    v.exp_maddr = maddr; v.exp_mwdata = mwd; v.exp_err = err;
    v.exp_rdata = erd; v.exp_cyc = cyc;
    return v;
  endfunction

  // Cycle numbering: the acceptance cycle is cycle 1.
  task automatic run_vec(input vec_t v, input string tag);
    int   reqs;
    logic bad;
    logic done;
    exp_t e;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    e.err = v.exp_err; e.rdata = v.exp_rdata; e.cyc = v.exp_cyc;
    sb_q.push_back(e);
    reqs = 0; bad = 1'b0; done = 1'b0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (resp_valid) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s_sb: actual=unexpected response required=none", tag);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check({tag, "_rdata"}, resp_rdata, e.rdata);
          check({tag, "_cycle"}, k + 1, e.cyc);
        end
      end else if (mem_req) begin
        reqs++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !==
            {v.exp_we, v.exp_be, v.exp_maddr, v.exp_mwdata}) begin
          bad = 1'b1;
          $display("%s mem fields: we=%b be=%h addr=%h wdata=%h", tag, mem_we, mem_be, mem_addr, mem_wdata);
        end
        if (reqs == v.ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: actual=no resp_valid required=resp_valid", tag);
      sb_q.delete();
    end
    check({tag, "_mem_req_cycles"}, reqs, v.exp_reqs);
    check({tag, "_mem_fields"}, {31'b0, bad}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check({tag, "_resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_rdata_hold"}, resp_rdata, v.exp_rdata);
    check({tag, "_err_hold"}, {31'b0, resp_err}, {31'b0, v.exp_err});
  endtask

  initial begin
    logic seen;
    //            op  f3      addr          wdata         rdata         ack rq we be     maddr         mwdata        er erdata        cyc
    vecs[0]  = mk(LD, F3_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1, 1, 0, 4'hF,  32'h100, 32'h0,        0, 32'hDEADBEEF, 3);
    vecs[1]  = mk(LD, F3_LB,  32'h103, 32'h0,        32'h80112233, 1, 1, 0, 4'hF,  32'h100, 32'h0,        0, 32'hFFFFFF80, 3);
    vecs[2]  = mk(LD, F3_LBU, 32'h103, 32'h0,        32'h80112233, 1, 1, 0, 4'hF,  32'h100, 32'h0,        0, 32'h00000080, 3);
    vecs[3]  = mk(LD, F3_LHU, 32'h102, 32'h0,        32'h80112233, 1, 1, 0, 4'hF,  32'h100, 32'h0,        0, 32'h00008011, 3);
    vecs[4]  = mk(LD, F3_LH,  32'h102, 32'h0,        32'h80112233, 2, 2, 0, 4'hF,  32'h100, 32'h0,        0, 32'hFFFF8011, 4);
    vecs[5]  = mk(LD, F3_LH,  32'h100, 32'h0,        32'h80112233, 1, 1, 0, 4'hF,  32'h100, 32'h0,        0, 32'h00002233, 3);
    vecs[6]  = mk(LD, F3_LB,  32'h101, 32'h0,        32'h80112233, 3, 3, 0, 4'hF,  32'h100, 32'h0,        0, 32'h00000022, 5);
    vecs[7]  = mk(ST, F3_SH,  32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, 1, 1, 4'hC,  32'h200, 32'hABCDABCD, 0, 32'h0,        3);
    vecs[8]  = mk(ST, F3_SB,  32'h301, 32'h000000A5, 32'hFFFFFFFF, 2, 2, 1, 4'h2,  32'h300, 32'hA5A5A5A5, 0, 32'h0,        4);
    vecs[9]  = mk(ST, F3_SW,  32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 1, 1, 4'hF,  32'h304, 32'hCAFEF00D, 0, 32'h0,        3);
    vecs[10] = mk(LD, F3_LW,  32'h101, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);
    vecs[11] = mk(LD, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);
    vecs[12] = mk(ST, F3_SH,  32'h203, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);
    vecs[13] = mk(ST, 3'b100, 32'h200, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);
    vecs[14] = mk(RT, 3'b000, 32'h200, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);
    vecs[15] = mk(LD, F3_LW,  32'h400, 32'h0,        32'h0,        0, TO, 0, 4'hF, 32'h400, 32'h0,        1, 32'h0,        TO + 2);
    vecs[16] = mk(LD, F3_LW,  32'h400, 32'h0,        32'h12345678, TO, TO, 0, 4'hF, 32'h400, 32'h0,     0, 32'h12345678, TO + 2);
    vecs[17] = mk(LD, F3_LHU, 32'h101, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,   32'h0,        1, 32'h0,        2);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_outputs", {29'b0, resp_valid, resp_err, mem_req}, 32'd0);
    check("rst_mem_be_we", {27'b0, mem_we, mem_be}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // mem_ack outside ACCESS must be ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_no_resp", {31'b0, resp_valid}, 32'd0);
    check("stray_ack_ready", {31'b0, req_ready}, 32'd1);
    check("stray_ack_no_req", {31'b0, mem_req}, 32'd0);

    // Reset in the middle of an access aborts without a response.
    @(negedge clk);
    req_valid = 1'b1; opcode = LD; funct3 = F3_LW; addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_mem_req_before", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_mem_req_drop", {31'b0, mem_req}, 32'd0);
    check("abort_ready_in_rst", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_req) seen = 1'b1;
    end
    check("abort_no_resp", {31'b0, seen}, 32'd0);
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    run_vec(vecs[0], "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
